// File: rtl/frame_pkg.sv
// Shared types and constants for the frame line reader.
// Lane layout of a 128-bit bus word holding four 24-bit RGB pixels.
package frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_WAIT,
    S_ERR
  } state_t;

  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned PIX_W        = 24;

  localparam logic [6:0] LANE0_LSB = 7'd96;
  localparam logic [6:0] LANE1_LSB = 7'd64;
  localparam logic [6:0] LANE2_LSB = 7'd32;
  localparam logic [6:0] LANE3_LSB = 7'd0;

  function automatic logic [6:0] lane_lsb(input logic [1:0] lane);
    logic [6:0] lsb;
    unique case (lane)
      2'd0:    lsb = LANE0_LSB;
      2'd1:    lsb = LANE1_LSB;
      2'd2:    lsb = LANE2_LSB;
      default: lsb = LANE3_LSB;
    endcase
    return lsb;
  endfunction

  // Pad bytes above each pixel fall off in the truncation.
  function automatic logic [PIX_W-1:0] lane_pix(
    input logic [127:0] word,
    input logic [1:0]   lane
  );
    return PIX_W'(word >> lane_lsb(lane));
  endfunction

endpackage

// File: rtl/frame_word_fifo.sv
// Synchronous first-word-fall-through FIFO for bus read words.
// Flush empties it in one cycle; push and pop together keep the count.
module frame_word_fifo #(
  parameter int W  = 128,
  parameter int LG = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [LG:0]   count
);

  localparam int DEPTH = 2 ** LG;

  logic [W-1:0]  mem [DEPTH];
  logic [LG-1:0] wr_ptr;
  logic [LG-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && (count != (LG+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_line_reader.sv
// Wishbone pipelined frame reader: fetches each line as 128-bit words
// and streams unpacked RGB pixels with end-of-line/frame markers.
module frame_line_reader
  import frame_pkg::*;
#(
  parameter int AW     = 24,
  parameter int XBITS  = 13,
  parameter int YBITS  = 11,
  parameter int LGFIFO = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [AW-1:0]    i_first_address,
  input  logic [AW-1:0]    i_words_per_line,
  input  logic [XBITS-1:0] i_npix,
  input  logic [YBITS-1:0] i_nlines,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic [AW-1:0]    o_wb_addr,
  input  logic             i_wb_ack,
  input  logic             i_wb_stall,
  input  logic             i_wb_err,
  input  logic [127:0]     i_wb_data,
  output logic             o_pix_valid,
  input  logic             i_pix_ready,
  output logic [7:0]       o_pix_r,
  output logic [7:0]       o_pix_g,
  output logic [7:0]       o_pix_b,
  output logic             o_pix_eol,
  output logic             o_pix_eof,
  output logic             o_err
);

  localparam int CW = LGFIFO + 2;
  localparam int WW = XBITS - 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** LGFIFO);

  state_t           state;
  logic [AW-1:0]    line_addr;
  logic [AW-1:0]    stride;
  logic [WW-1:0]    words;
  logic [WW-1:0]    issued;
  logic [WW-1:0]    words_in;
  logic [XBITS:0]   npix_up;
  logic [XBITS-1:0] npix_q;
  logic [YBITS-1:0] nlines_q;
  logic [YBITS-1:0] y;
  logic [LGFIFO:0]  outst;
  logic [LGFIFO:0]  outst_n;
  logic [LGFIFO:0]  fifo_cnt;
  logic [CW-1:0]    total;
  logic             accept;
  logic             ack;
  logic             err_evt;
  logic             start;
  logic             last_req;

  logic [127:0]     fifo_data;
  logic             fifo_empty;
  logic             pop;
  logic [127:0]     word_q;
  logic             have;
  logic [1:0]       lane;
  logic [XBITS-1:0] px;
  logic [YBITS-1:0] py;
  logic             fire;
  logic             word_done;
  logic [23:0]      pix;

  assign npix_up  = {1'b0, i_npix} + (XBITS+1)'(3);
  assign words_in = npix_up[XBITS:2];
  assign accept   = o_wb_stb && !i_wb_stall;
  assign ack      = o_wb_cyc && i_wb_ack;
  assign err_evt  = o_wb_cyc && i_wb_err;
  assign last_req = accept && ((issued + 1'b1) == words);

  // Waiting for the pixel path to drain keeps the latched geometry
  // consistent with the words still being unpacked.
  assign start = i_en && (i_npix != '0) && (i_nlines != '0)
              && fifo_empty && !have;

  // Occupancy after this edge if nothing is popped; a pop only frees room.
  assign total = CW'(fifo_cnt) + CW'(outst) + CW'(accept);

  always_comb begin
    outst_n = outst;
    if (accept && !ack)
      outst_n = outst + 1'b1;
    else if (!accept && ack)
      outst_n = outst - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_addr <= '0;
      o_err     <= 1'b0;
      line_addr <= '0;
      stride    <= '0;
      words     <= '0;
      issued    <= '0;
      npix_q    <= '0;
      nlines_q  <= '0;
      y         <= '0;
      outst     <= '0;
    end else if (err_evt) begin
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_err    <= 1'b1;
      outst    <= '0;
      state    <= S_ERR;
    end else begin
      outst <= outst_n;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            npix_q    <= i_npix;
            nlines_q  <= i_nlines;
            words     <= words_in;
            stride    <= (i_words_per_line == '0)
                         ? AW'(words_in) : i_words_per_line;
            line_addr <= i_first_address;
            o_wb_addr <= i_first_address;
            y         <= '0;
            issued    <= '0;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            state     <= S_LINE;
          end
        end
        S_LINE: begin
          if (accept) begin
            o_wb_addr <= o_wb_addr + 1'b1;
            issued    <= issued + 1'b1;
          end
          if (last_req) begin
            o_wb_stb <= 1'b0;
            state    <= S_WAIT;
          end else begin
            o_wb_stb <= (total < DEPTH);
          end
        end
        S_WAIT: begin
          if (o_wb_cyc) begin
            if (outst_n == '0) o_wb_cyc <= 1'b0;
          end else if (y == nlines_q - 1'b1) begin
            state <= S_IDLE;
          end else begin
            y         <= y + 1'b1;
            line_addr <= line_addr + stride;
            o_wb_addr <= line_addr + stride;
            issued    <= '0;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= ({1'b0, fifo_cnt} < DEPTH);
            state     <= S_LINE;
          end
        end
        S_ERR: begin
          if (!i_en) begin
            o_err <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  frame_word_fifo #(
    .W  (128),
    .LG (LGFIFO)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .flush (err_evt),
    .push  (ack && !i_wb_err),
    .wdata (i_wb_data),
    .pop   (pop),
    .rdata (fifo_data),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign fire      = have && i_pix_ready;
  assign o_pix_eol = have && (px == npix_q - 1'b1);
  assign o_pix_eof = o_pix_eol && (py == nlines_q - 1'b1);
  assign word_done = fire && (o_pix_eol || lane == 2'd3);
  assign pop       = (!have || word_done) && !fifo_empty;

  assign o_pix_valid = have;
  assign pix         = lane_pix(word_q, lane);
  assign o_pix_r     = pix[23:16];
  assign o_pix_g     = pix[15:8];
  assign o_pix_b     = pix[7:0];

  // A line's last word may end mid-word; leftover lanes are dropped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      word_q <= '0;
      have   <= 1'b0;
      lane   <= '0;
      px     <= '0;
      py     <= '0;
    end else if (err_evt) begin
      have <= 1'b0;
      lane <= '0;
      px   <= '0;
      py   <= '0;
    end else begin
      if (fire) begin
        if (o_pix_eol) begin
          px <= '0;
          py <= o_pix_eof ? '0 : py + 1'b1;
        end else begin
          px   <= px + 1'b1;
          lane <= lane + 1'b1;
        end
      end
      if (pop) begin
        word_q <= fifo_data;
        have   <= 1'b1;
        lane   <= '0;
      end else if (word_done) begin
        have <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_line_reader.sv
// Randomized scoreboard bench for frame_line_reader with a
// Wishbone slave model and a frame-level pixel reference model.
module tb_frame_line_reader;

  localparam int AW     = 24;
  localparam int XBITS  = 13;
  localparam int YBITS  = 11;
  localparam int LGFIFO = 2;
  localparam int DEPTH  = 4;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             i_en = 1'b0;
  logic [AW-1:0]    i_first_address = '0;
  logic [AW-1:0]    i_words_per_line = '0;
  logic [XBITS-1:0] i_npix = '0;
  logic [YBITS-1:0] i_nlines = '0;
  logic             o_wb_cyc;
  logic             o_wb_stb;
  logic [AW-1:0]    o_wb_addr;
  logic             i_wb_ack = 1'b0;
  logic             i_wb_stall = 1'b0;
  logic             i_wb_err = 1'b0;
  logic [127:0]     i_wb_data = '0;
  logic             o_pix_valid;
  logic             i_pix_ready = 1'b0;
  logic [7:0]       o_pix_r;
  logic [7:0]       o_pix_g;
  logic [7:0]       o_pix_b;
  logic             o_pix_eol;
  logic             o_pix_eof;
  logic             o_err;

  frame_line_reader #(
    .AW(AW), .XBITS(XBITS), .YBITS(YBITS), .LGFIFO(LGFIFO)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
    .i_first_address(i_first_address),
    .i_words_per_line(i_words_per_line),
    .i_npix(i_npix), .i_nlines(i_nlines),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data),
    .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
    .o_pix_r(o_pix_r), .o_pix_g(o_pix_g), .o_pix_b(o_pix_b),
    .o_pix_eol(o_pix_eol), .o_pix_eof(o_pix_eof), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [23:0] rgb;
    logic        eol;
    logic        eof;
  } pix_t;

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } req_t;

  pix_t          exp_pix[$];
  logic [AW-1:0] exp_addr[$];
  req_t          pend[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int lat = 1;
  int stall_mode = 0;
  int ready_mode = 0;
  int rdy_hold = 0;
  int err_at = 0;
  int ack_n = 0;
  int line_words = 1;
  int accepted = 0;
  int retired = 0;
  int xcnt = 0;
  bit chk_drop = 0;
  bit chk_err = 0;
  bit chk_hold = 1;
  bit held_valid = 0;
  logic [24:0] held;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] pixval(input logic [AW-1:0] a,
                                         input int lane);
    logic [31:0] v;
    v = 32'(a) * 32'h9E37 + 32'(lane) * 32'h1F3 + 32'h10101;
    return v[23:0] ^ {v[31:24], 16'h0};
  endfunction

  function automatic logic [127:0] word_of(input logic [AW-1:0] a);
    logic [127:0] w;
    w = {4{8'hC3, 24'h0}};
    for (int l = 0; l < 4; l++) w[119-32*l -: 24] = pixval(a, l);
    return w;
  endfunction

  // Reference: pixel x of line y lives in word base+y*stride+x/4, lane x%4.
  task automatic expect_frame(input logic [AW-1:0] base, input int stride_in,
                              input int npix, input int nlines);
    int wpl;
    int st;
    logic [AW-1:0] a;
    pix_t p;
    wpl = (npix + 3) / 4;
    st = (stride_in == 0) ? wpl : stride_in;
    for (int yy = 0; yy < nlines; yy++) begin
      for (int w = 0; w < wpl; w++)
        exp_addr.push_back(base + AW'(yy * st + w));
      for (int x = 0; x < npix; x++) begin
        a = base + AW'(yy * st + x / 4);
        p.rgb = pixval(a, x % 4);
        p.eol = (x == npix - 1);
        p.eof = (x == npix - 1) && (yy == nlines - 1);
        exp_pix.push_back(p);
      end
    end
  endtask

  // Monitor: bus requests and pixel transfers, sampled mid-cycle.
  always @(negedge i_clk) begin
    pix_t got;
    pix_t ex;
    if (!i_reset_n) begin
      held_valid = 0;
    end else begin
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        accepted++;
        if (exp_addr.size() == 0) check("addr_extra", 1, 0);
        else check("addr", 64'(o_wb_addr), 64'(exp_addr.pop_front()));
        pend.push_back('{o_wb_addr, cyc_n + lat});
      end
      if (chk_hold && held_valid)
        check("hold", {o_pix_valid, o_pix_r, o_pix_g, o_pix_b},
              {1'b1, held[23:0]});
      held_valid = o_pix_valid && !i_pix_ready;
      held = {1'b1, o_pix_r, o_pix_g, o_pix_b};
      if (o_pix_valid && i_pix_ready) begin
        got = {o_pix_r, o_pix_g, o_pix_b, o_pix_eol, o_pix_eof};
        if (exp_pix.size() == 0) begin
          check("pix_extra", 1, 0);
        end else begin
          ex = exp_pix.pop_front();
          check("pixel", 64'(got), 64'(ex));
          if (ex.eol || xcnt % 4 == 3) retired++;
          xcnt = ex.eol ? 0 : xcnt + 1;
        end
      end
      check("fifo_bound", 64'((accepted - retired) <= DEPTH + 1), 1);
    end
  end

  // Slave and ready driver: update inputs 1 time unit after each edge.
  always @(posedge i_clk) begin
    #1;
    cyc_n++;
    if (chk_drop) begin
      check("cyc_after_last_ack", 64'(o_wb_cyc), 0);
      chk_drop = 0;
    end
    if (chk_err) begin
      check("err_cyc", 64'(o_wb_cyc), 0);
      check("err_flag", 64'(o_err), 1);
      chk_err = 0;
    end
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    if (!i_reset_n) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      req_t r;
      r = pend.pop_front();
      ack_n++;
      if (err_at != 0 && ack_n == err_at) begin
        i_wb_err = 1'b1;
        chk_err = 1;
        pend.delete();
      end else begin
        i_wb_ack = 1'b1;
        i_wb_data = word_of(r.a);
        if (ack_n % line_words == 0) chk_drop = 1;
      end
    end
    case (stall_mode)
      0: i_wb_stall = 1'b0;
      1: i_wb_stall = ~i_wb_stall;
      default: i_wb_stall = ($urandom_range(0, 1) == 0);
    endcase
    if (rdy_hold > 0) begin
      i_pix_ready = 1'b0;
      rdy_hold--;
    end else begin
      i_pix_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_frame(input logic [AW-1:0] base, input int stride,
                             input int npix, input int nlines);
    int t;
    ack_n = 0;
    line_words = (npix + 3) / 4;
    expect_frame(base, stride, npix, nlines);
    @(negedge i_clk);
    i_first_address = base;
    i_words_per_line = AW'(stride);
    i_npix = XBITS'(npix);
    i_nlines = YBITS'(nlines);
    i_en = 1'b1;
    t = 0;
    while (!o_wb_cyc && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check("frame_start", 64'(o_wb_cyc), 1);
    i_en = 1'b0;
    i_npix = XBITS'($urandom_range(1, 40));
    i_nlines = YBITS'($urandom_range(1, 5));
    i_first_address = AW'($urandom);
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int stride,
                           input int npix, input int nlines, input int l,
                           input int sm, input int rm, input int hold);
    int t;
    lat = l;
    stall_mode = sm;
    ready_mode = rm;
    rdy_hold = hold;
    start_frame(base, stride, npix, nlines);
    t = 0;
    while ((exp_pix.size() != 0 || exp_addr.size() != 0 || o_wb_cyc)
           && t < 5000) begin
      @(negedge i_clk);
      t++;
    end
    check("frame_done", 64'(t < 5000), 1);
    repeat (3) @(negedge i_clk);
    check("idle_cyc", 64'(o_wb_cyc), 0);
    check("idle_valid", 64'(o_pix_valid), 0);
    exp_pix.delete();
    exp_addr.delete();
  endtask

  initial begin
    int t;
    repeat (3) @(negedge i_clk);
    check("rst_cyc", 64'(o_wb_cyc), 0);
    check("rst_stb", 64'(o_wb_stb), 0);
    check("rst_addr", 64'(o_wb_addr), 0);
    check("rst_valid", 64'(o_pix_valid), 0);
    check("rst_err", 64'(o_err), 0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);

    i_npix = '0;
    i_nlines = YBITS'(2);
    i_en = 1'b1;
    repeat (8) @(negedge i_clk);
    check("npix0_no_start", 64'(o_wb_cyc), 0);
    i_en = 1'b0;

    run_frame(AW'('h100), 0, 8, 2, 1, 0, 0, 0);
    run_frame(AW'(0), 4, 6, 2, 1, 0, 0, 0);
    run_frame(AW'('h300), 0, 13, 3, 2, 0, 1, 100);
    run_frame(AW'('h500), 0, 16, 2, 3, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      int np;
      int st;
      np = $urandom_range(1, 24);
      st = ($urandom_range(0, 1) == 0) ? 0 : (np + 3) / 4 + $urandom_range(0, 3);
      run_frame(AW'($urandom_range(0, 'hFFFF)), st, np,
                $urandom_range(1, 4), $urandom_range(1, 4),
                $urandom_range(0, 2), $urandom_range(0, 1), 0);
    end

    chk_hold = 0;
    err_at = 2;
    lat = 1;
    stall_mode = 0;
    rdy_hold = 1000;
    ack_n = 0;
    line_words = 4;
    expect_frame(AW'('h200), 0, 16, 1);
    @(negedge i_clk);
    i_first_address = AW'('h200);
    i_words_per_line = '0;
    i_npix = XBITS'(16);
    i_nlines = YBITS'(1);
    i_en = 1'b1;
    t = 0;
    while (!o_err && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    check("err_seen", 64'(o_err), 1);
    repeat (5) @(negedge i_clk);
    check("err_sticky", 64'(o_err), 1);
    check("err_hold_cyc", 64'(o_wb_cyc), 0);
    check("err_flushed", 64'(o_pix_valid), 0);
    i_en = 1'b0;
    repeat (2) @(negedge i_clk);
    check("err_cleared", 64'(o_err), 0);
    exp_pix.delete();
    exp_addr.delete();
    err_at = 0;
    rdy_hold = 0;
    accepted = 0;
    retired = 0;
    xcnt = 0;
    chk_hold = 1;
    run_frame(AW'('h280), 0, 5, 1, 1, 0, 0, 0);

    chk_hold = 0;
    lat = 2;
    ready_mode = 1;
    start_frame(AW'('h40), 0, 16, 2);
    t = 0;
    while (accepted - retired < 2 && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_cyc", 64'(o_wb_cyc), 0);
    check("mid_rst_stb", 64'(o_wb_stb), 0);
    check("mid_rst_addr", 64'(o_wb_addr), 0);
    check("mid_rst_valid", 64'(o_pix_valid), 0);
    check("mid_rst_eol", 64'({o_pix_eol, o_pix_eof}), 0);
    check("mid_rst_err", 64'(o_err), 0);
    exp_pix.delete();
    exp_addr.delete();
    chk_drop = 0;
    repeat (3) @(negedge i_clk);
    accepted = 0;
    retired = 0;
    xcnt = 0;
    i_reset_n = 1'b1;
    chk_hold = 1;
    run_frame(AW'('h40), 0, 16, 2, 2, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_line_reader.md
FRAME_LINE_READER -- requirements
Module: frame_line_reader

Interface
REQ-001 SHALL have parameter AW, default 24, meaning Wishbone word-address width.
REQ-002 SHALL have parameter XBITS, default 13, meaning pixel-count width.
REQ-003 SHALL have parameter YBITS, default 11, meaning line-count width.
REQ-004 SHALL have parameter LGFIFO, default 5, meaning log2 of word-FIFO depth.
REQ-005 SHALL have port i_clk, input, 1, meaning the single clock.
REQ-006 SHALL have port i_reset_n, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port i_en, input, 1, meaning enable frame reads.
REQ-008 SHALL have port i_first_address, input, AW, meaning word address of pixel (0,0).
REQ-009 SHALL have port i_words_per_line, input, AW, meaning line stride in words; 0 selects ceil(npix/4).
REQ-010 SHALL have port i_npix, input, XBITS, meaning pixels per line.
REQ-011 SHALL have port i_nlines, input, YBITS, meaning lines per frame.
REQ-012 SHALL have ports o_wb_cyc and o_wb_stb, output, 1 each, meaning Wishbone pipelined read master strobes (we=0 implied).
REQ-013 SHALL have port o_wb_addr, output, AW, meaning word address.
REQ-014 SHALL have ports i_wb_ack, i_wb_stall, i_wb_err, input, 1 each, meaning Wishbone responses.
REQ-015 SHALL have port i_wb_data, input, 128, meaning read data.
REQ-016 SHALL have ports o_pix_valid (output, 1) and i_pix_ready (input, 1), meaning pixel stream handshake.
REQ-017 SHALL have ports o_pix_r, o_pix_g, o_pix_b, output, 8 each, meaning pixel colour.
REQ-018 SHALL have ports o_pix_eol and o_pix_eof, output, 1 each, meaning last pixel of line / of frame, qualified by o_pix_valid.
REQ-019 SHALL have port o_err, output, 1, meaning sticky bus-error flag.

Function
REQ-020 SHALL run states IDLE, LINE, WAIT, ERR; IDLE->LINE when i_en and npix!=0 and nlines!=0, latching all configuration inputs.
REQ-021 SHALL, in LINE, issue ceil(npix/4) reads from line_address upward, o_wb_addr incrementing on each stb&&!stall.
REQ-022 SHALL raise stb only while (FIFO occupancy + outstanding acks) < 2^LGFIFO, so every ack is accepted without overflow.
REQ-023 SHALL, after the last request of a line, drop stb and enter WAIT; on final ack drop cyc; next cycle line_address += stride, y += 1, return to LINE, or IDLE after the last line.
REQ-024 SHALL unpack each word with first pixel at bits [119:96], then [87:64], [55:32], [23:0]; bytes R,G,B high to low; bits [127:120],[95:88],[63:56],[31:24] ignored.
REQ-025 SHALL discard unused lane pixels of a line's last word when npix mod 4 != 0; next line starts at lane 0.
REQ-026 SHALL hold o_pix_* stable while o_pix_valid && !i_pix_ready; a transfer occurs on valid && ready.
REQ-027 SHALL assert o_pix_eol on pixel npix-1 of every line and o_pix_eof additionally on the last line.
REQ-028 SHALL ignore i_en falling mid-frame; the frame completes, then IDLE.
REQ-029 SHALL, on i_wb_err while cyc, clear cyc/stb next edge, flush FIFO and unpacker, set o_err, enter ERR; ERR->IDLE and o_err clear when i_en is low.
REQ-030 SHALL handle simultaneous FIFO push and pop without occupancy change; outstanding count unchanged on simultaneous stb-accept and ack.
REQ-031 SHALL ignore acks while cyc is low.

Reset
REQ-032 SHALL, while i_reset_n low, force o_wb_cyc, o_wb_stb, o_pix_valid, o_pix_eol, o_pix_eof, o_err to 0, o_wb_addr to 0, FIFO empty, state IDLE.
REQ-033 SHALL abandon any in-progress cycle on reset; the first frame after release starts at line 0.

Structure
REQ-034 SHALL place state encoding, PIX_PER_WORD=4 and lane bit offsets in shared package frame_pkg.
REQ-035 SHALL instantiate one sub-module, sync FIFO frame_word_fifo (128 bits wide, 2^LGFIFO deep).

Verification
REQ-036 SHALL cover: npix=8, nlines=2, stride=0, base 0x100, zero-wait slave -> reads 0x100,0x101,0x102,0x103; 16 pixels; eol at 8,16; eof at 16.
REQ-037 SHALL cover: npix=6, stride=4, base 0 -> reads 0,1,4,5; per line pixels = lanes 0-3 of word 0 then lanes 0-1 of word 1.
REQ-038 SHALL cover: i_pix_ready low for 100 cycles, LGFIFO=2 -> at most 4 words outstanding+buffered, no pixel lost or duplicated.
REQ-039 SHALL cover: i_wb_stall toggling every cycle, 3-cycle ack latency -> addresses strictly sequential, cyc drops one cycle after final ack.
REQ-040 SHALL cover: i_wb_err on second ack -> cyc=0 next cycle, o_err=1 until i_en low, then IDLE.
REQ-041 SHALL cover: i_reset_n low mid-line -> all outputs at reset values immediately, next frame restarts at base address.
